// File: rtl/clb_tile_config_store.sv
// Multi-context configuration store for one CLB tile: beat-stream loader,
// single-cycle context switch, and a snapshot-based readback stream.
module clb_tile_config_store #(
   parameter int CONF_W  = 256,
   parameter int SHIFT_W = 8,
   parameter int NCTX    = 2,
   parameter int CTX_W   = (NCTX > 1) ? $clog2(NCTX) : 1,
   parameter int BEATS   = (CONF_W + SHIFT_W - 1) / SHIFT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [SHIFT_W-1:0] cfg_data,
   input  logic [CTX_W-1:0]   cfg_ctx,
   input  logic               cfg_last,
   input  logic               ctx_switch,
   input  logic [CTX_W-1:0]   ctx_next,
   output logic [CTX_W-1:0]   active_ctx,
   output logic [CONF_W-1:0]  conf_out,
   input  logic               rb_start,
   output logic               rb_valid,
   input  logic               rb_ready,
   output logic [SHIFT_W-1:0] rb_data,
   output logic               rb_last,
   output logic               cfg_err,
   input  logic               err_clr
);

   localparam int FRAME_W = BEATS * SHIFT_W;
   localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      LOAD,
      DRAIN,
      COMMIT
   } state_t;

   state_t                           state, state_nxt;
   logic [CNT_W-1:0]                 beat_cnt, cnt_nxt;
   logic [CTX_W-1:0]                 frame_ctx, ctx_nxt;
   logic [BEATS-1:0][SHIFT_W-1:0]    stage;
   logic [FRAME_W-1:0]               stage_flat;
   logic [CONF_W-1:0]                slot [NCTX];
   logic                             accept;
   logic                             stage_we;
   logic                             load_err;
   logic                             commit;
   logic [CTX_W-1:0]                 active_nxt;
   logic                             switch_err;
   logic [BEATS-1:0][SHIFT_W-1:0]    rb_snap;
   logic [CNT_W-1:0]                 rb_cnt;

   function automatic logic ctx_ok(input logic [CTX_W-1:0] c);
      return int'(c) < NCTX;
   endfunction

   assign cfg_ready  = !reset && (state != COMMIT);
   assign accept     = cfg_valid && cfg_ready;
   assign stage_flat = stage;

   // Loader FSM: next state, beat counter and error detection
   always_comb begin
      state_nxt = state;
      cnt_nxt   = beat_cnt;
      ctx_nxt   = frame_ctx;
      stage_we  = 1'b0;
      load_err  = 1'b0;
      commit    = 1'b0;
      case (state)
         LOAD: begin
            if (accept) begin
               stage_we = 1'b1;
               cnt_nxt  = beat_cnt + 1'b1;
               if (beat_cnt == '0) begin
                  ctx_nxt = cfg_ctx;
               end
               if (beat_cnt == '0 && !ctx_ok(cfg_ctx)) begin
                  load_err  = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = cfg_last ? LOAD : DRAIN;
               end else if (cfg_last) begin
                  cnt_nxt = '0;
                  if (beat_cnt == LAST_BEAT) begin
                     state_nxt = COMMIT;
                  end else begin
                     load_err = 1'b1;
                  end
               end else if (beat_cnt == LAST_BEAT) begin
                  load_err  = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (accept && cfg_last) begin
               state_nxt = LOAD;
            end
         end
         COMMIT: begin
            commit    = 1'b1;
            state_nxt = LOAD;
         end
         default: begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LOAD;
         beat_cnt  <= '0;
         frame_ctx <= '0;
         stage     <= '0;
      end else begin
         state     <= state_nxt;
         beat_cnt  <= cnt_nxt;
         frame_ctx <= ctx_nxt;
         if (stage_we) begin
            stage[beat_cnt] <= cfg_data;
         end
      end
   end

   always_comb begin
      active_nxt = active_ctx;
      switch_err = 1'b0;
      if (ctx_switch) begin
         if (ctx_ok(ctx_next)) begin
            active_nxt = ctx_next;
         end else begin
            switch_err = 1'b1;
         end
      end
   end

   // conf_out follows the context that will be active next; a commit to that
   // context is forwarded so it appears on the same edge as the slot write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NCTX; i++) begin
            slot[i] <= '0;
         end
         active_ctx <= '0;
         conf_out   <= '0;
      end else begin
         if (commit) begin
            slot[frame_ctx] <= stage_flat[CONF_W-1:0];
         end
         active_ctx <= active_nxt;
         if (commit && frame_ctx == active_nxt) begin
            conf_out <= stage_flat[CONF_W-1:0];
         end else begin
            conf_out <= slot[active_nxt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_err <= 1'b0;
      end else if (load_err || switch_err) begin
         cfg_err <= 1'b1;
      end else if (err_clr) begin
         cfg_err <= 1'b0;
      end
   end

   // Readback streams a private snapshot, so later switches/commits cannot
   // disturb a transfer in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         rb_valid <= 1'b0;
         rb_cnt   <= '0;
         rb_snap  <= '0;
      end else if (!rb_valid) begin
         if (rb_start) begin
            rb_snap  <= FRAME_W'(conf_out);
            rb_valid <= 1'b1;
            rb_cnt   <= '0;
         end
      end else if (rb_ready) begin
         if (rb_cnt == LAST_BEAT) begin
            rb_valid <= 1'b0;
            rb_cnt   <= '0;
         end else begin
            rb_cnt <= rb_cnt + 1'b1;
         end
      end
   end

   assign rb_data = rb_snap[rb_cnt];
   assign rb_last = rb_valid && (rb_cnt == LAST_BEAT);

endmodule

// File: doc/clb_tile_config_store.md
Name: clb_tile_config_store

Overview:
- Multi-context configuration store for one CLB tile.
- Loads switch-box, connection-block, CLB-IO and carry-mux configuration bits from a ready/valid beat stream into one of NCTX context slots.
- Drives the active context as a flat registered bus, which the tile slices into its conf_* fields.
- Supports single-cycle context switching and a consistent readback stream. Sits beside each clb_tile on the configuration network.

Parameters:
- CONF_W, 256: total tile configuration bits (sum of the tile's conf_* widths).
- SHIFT_W, 8: bits per configuration beat.
- NCTX, 2: number of stored contexts; must be ≥1.
- CTX_W, max(1,$clog2(NCTX)): context index width (derived).
- BEATS, ceil(CONF_W/SHIFT_W): beats per frame (derived).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  beat valid.
- cfg_ready  out  1  store accepts beat.
- cfg_data  in  SHIFT_W  beat payload.
- cfg_ctx  in  CTX_W  target context; sampled on first beat only.
- cfg_last  in  1  final beat of frame.
- ctx_switch  in  1  pulse: make ctx_next active.
- ctx_next  in  CTX_W  requested active context.
- active_ctx  out  CTX_W  current active context.
- conf_out  out  CONF_W  active configuration to tile.
- rb_start  in  1  pulse: begin readback.
- rb_valid  out  1  readback beat valid.
- rb_ready  in  1  readback consumer ready.
- rb_data  out  SHIFT_W  readback payload.
- rb_last  out  1  final readback beat.
- cfg_err  out  1  sticky error flag.
- err_clr  in  1  clears cfg_err.

Behaviour:
- Reset: all context slots, staging, conf_out = 0. active_ctx=0. cfg_ready=0 during reset, 1 the cycle after. rb_valid=0, rb_last=0, cfg_err=0. FSM enters LOAD with beat_cnt=0. Reset mid-frame or mid-readback discards all progress.
- Beat k fills conf bits [k*SHIFT_W +: SHIFT_W]. Bits beyond CONF_W in the last beat are ignored. A beat is accepted when cfg_valid && cfg_ready.
- FSM states:
  - LOAD (cfg_ready=1): on accept, write staging and increment beat_cnt. Latch frame_ctx at beat_cnt=0.
    - Accept with beat_cnt=BEATS-1 and cfg_last=1 → COMMIT.
    - cfg_last=1 before BEATS-1 → set cfg_err, discard frame, stay in LOAD with beat_cnt=0.
    - beat_cnt=BEATS-1 accepted without cfg_last → set cfg_err, go to DRAIN.
    - frame_ctx ≥ NCTX → set cfg_err, go to DRAIN (or discard immediately if that beat is also last).
  - DRAIN (cfg_ready=1): discard beats until an accepted cfg_last, then LOAD with beat_cnt=0.
  - COMMIT (cfg_ready=0, exactly 1 cycle): slot[frame_ctx] <= staging, then LOAD.
- A failed frame never modifies any slot.
- Context switch:
  - ctx_switch with ctx_next < NCTX sets active_ctx on the next edge.
  - ctx_next ≥ NCTX is ignored and sets cfg_err.
- conf_out is registered as conf_out <= slot[active_ctx_next] with write-through. Latency is 1 cycle from a switch pulse or from COMMIT to the active context.
- Commit and switch in the same cycle: both take effect. If the commit targets the new active context, conf_out shows the committed data at t+1.
- Readback:
  - rb_start while idle snapshots conf_out and raises rb_valid next cycle.
  - Beat k of the snapshot is presented in order. Pad bits beyond CONF_W read 0.
  - A beat advances on rb_valid && rb_ready. rb_data and rb_valid are held stable under backpressure.
  - rb_last is asserted with beat BEATS-1. rb_valid drops after that beat is accepted.
  - rb_start while busy is ignored. Later switches or commits do not alter the in-flight snapshot.
- cfg_err: sets on any error listed above and stays set until err_clr or reset. If err_clr coincides with a new error, the set wins.

Test Plan:
- Parameters CONF_W=20, SHIFT_W=8, NCTX=2. Stream ctx=0, beats 0xA5, 0x3C, 0x0F (last on beat 2) → one COMMIT cycle with cfg_ready=0; conf_out=0xF3CA5 one cycle after COMMIT; cfg_err=0.
- Load ctx=1 with 0x12, 0x34, 0x05, then pulse ctx_switch with ctx_next=1 → active_ctx=1 and conf_out=0x53412 the next cycle; switch back to 0 → conf_out=0xF3CA5.
- cfg_last on beat 1, then a 4-beat frame with no last on beat 2 → cfg_err=1, beats absorbed through DRAIN, slot contents unchanged; err_clr → cfg_err=0.
- With ctx 1 active, issue ctx_next=1 switch in the same cycle as the COMMIT of new ctx-1 data 0x00001 → conf_out=0x00001 at t+1, with no intermediate stale value.
- rb_start with conf_out=0xF3CA5 and rb_ready toggling 1,0,1,0,1 → rb_data 0xA5, 0x3C, 0x0F, each held while rb_ready=0; rb_last only on 0x0F; a switch mid-readback does not change the data.
- Assert reset mid-frame after beat 1 → conf_out=0, active_ctx=0, cfg_ready=0 during reset; the next full frame loads correctly from beat 0.
